// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: request sizes, FSM states and byte-lane helpers.
// Lane helpers fold sub-size address bits so misaligned accesses snap to their natural boundary.
package mau_pkg;

    localparam int WORD_W = 32;
    localparam int LANE_W = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] LANE_0 = 2'd0;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    // Lowest lane touched by an access; halves and words are forced to their natural boundary.
    function automatic logic [1:0] eff_lane(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return addr_lo;
            SZ_HALF: return {addr_lo[1], 1'b0};
            default: return LANE_0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane alignment: extracts/extends load data and merges store data into a read word.
// Purely combinational; little-endian lanes, lane k = bits [8k+7:8k].
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] store_word
);

    logic [4:0]        sh;
    logic [WORD_W-1:0] shifted;
    logic [WORD_W-1:0] mask;

    always_comb begin
        sh        = {eff_lane(size, addr_lo), 3'b000};
        shifted   = word >> sh;
        load_data = word;
        mask      = '1;
        case (size)
            SZ_BYTE: begin
                load_data = {{(WORD_W-LANE_W){is_signed & shifted[LANE_W-1]}}, shifted[LANE_W-1:0]};
                mask      = 32'h0000_00FF << sh;
            end
            SZ_HALF: begin
                load_data = {{(WORD_W-2*LANE_W){is_signed & shifted[2*LANE_W-1]}}, shifted[2*LANE_W-1:0]};
                mask      = 32'h0000_FFFF << sh;
            end
            default: ;
        endcase
        // Shifted-up wdata bits beyond the access size fall outside the mask and are dropped.
        store_word = (word & ~mask) | ((wdata << sh) & mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle byte/half/word load-store initiator in front of a word-wide DataMemory.
// MAU_MISALIGN_TRAP_EN: when defined, misaligned halves/words complete as error responses.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_t            state, state_nxt;
    logic              we_q, signed_q, err_q;
    logic [1:0]        size_q, lane_q;
    logic [DATA_W-1:0] wdata_q, word_q;
    logic [DATA_W-1:0] align_word, load_data, store_word;
    logic              req_err, accept;

    always_comb begin
`ifdef MAU_MISALIGN_TRAP_EN
        req_err = (req_size == SZ_RSVD) || misaligned(req_size, req_addr[1:0]);
`else
        req_err = (req_size == SZ_RSVD);
`endif
    end

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        mem_write_en   = 1'b0;
        resp_valid     = 1'b0;
        resp_err       = 1'b0;
        mem_write_data = store_word;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                              state_nxt = DONE;
                    else if (req_we && (req_size == SZ_WORD)) state_nxt = WRITE;
                    else                                      state_nxt = READ;
                end
            end
            READ:  state_nxt = we_q ? WRITE : DONE;
            WRITE: begin
                mem_write_en = 1'b1;
                state_nxt    = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Loads extract straight from the live read data; merges use the captured word.
    assign align_word = (state == READ) ? mem_read_data : word_q;

    mau_lane_align u_align (
        .word       (align_word),
        .addr_lo    (lane_q),
        .size       (size_q),
        .is_signed  (signed_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q       <= 1'b0;
            signed_q   <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= SZ_BYTE;
            lane_q     <= 2'b00;
            wdata_q    <= '0;
            word_q     <= '0;
            resp_rdata <= '0;
            mem_addr   <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                signed_q <= req_signed;
                err_q    <= req_err;
                size_q   <= req_size;
                lane_q   <= req_addr[1:0];
                wdata_q  <= req_wdata;
                if (!req_err) mem_addr <= {2'b00, req_addr[ADDR_W-1:2]};
            end
            if (state == READ) begin
                word_q <= mem_read_data;
                if (!we_q) resp_rdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model.
// Expected values are hand-derived; MAU_MISALIGN_TRAP_EN selects the misaligned-access expectation.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_addr;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:255];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] last_waddr;
    logic [31:0] last_wdata;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write_en) mem[mem_addr[7:0]] <= mem_write_data;
    assign mem_read_data = mem[mem_addr[7:0]];

    mem_access_unit dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_addr       (mem_addr),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request; exp_wr is the cycle after accept where mem_write_en must be high (0 = never).
    task automatic run_req(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                           input logic [15:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input int exp_wr, input logic exp_err);
        int   lat, wr_cnt, wr_at;
        logic err;
        lat = 0; wr_cnt = 0; wr_at = 0; err = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        // Scramble the request fields after accept; they must have no effect.
        req_valid = 1'b0; req_we = ~we; req_size = ~size; req_signed = ~sgn;
        req_addr = ~addr; req_wdata = ~wdata;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_write_en) begin
                wr_cnt++; wr_at = c;
                last_waddr = mem_addr; last_wdata = mem_write_data;
            end
            if (resp_valid) begin
                lat = c; err = resp_err;
                break;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_wr_cnt"}, wr_cnt, (exp_wr != 0) ? 1 : 0);
        check({tag, "_wr_at"}, wr_at, exp_wr);
        check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    endtask

    initial begin
        int   acc, resp_cnt;
        logic [8:0] rdy_bits;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_write_en", {31'b0, mem_write_en}, 32'd0);
        check("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        reset = 1'b0;

        run_req("ws0", 1'b1, 2'b10, 1'b0, 16'h0000, 32'hCAFE_F00D, 2, 1, 1'b0);
        run_req("ws_dead", 1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEAD_BEEF, 2, 1, 1'b0);
        check("ws_dead_addr", {16'b0, last_waddr}, 32'h0000_0004);
        check("ws_dead_data", last_wdata, 32'hDEAD_BEEF);
        check("ws_dead_mem", mem[4], 32'hDEAD_BEEF);

        run_req("ws_pat", 1'b1, 2'b10, 1'b0, 16'h0010, 32'h80FF_7F01, 2, 1, 1'b0);
        run_req("lb11s", 1'b0, 2'b00, 1'b1, 16'h0011, 32'h0, 2, 0, 1'b0);
        check("lb11s_data", resp_rdata, 32'h0000_007F);
        run_req("lb13u", 1'b0, 2'b00, 1'b0, 16'h0013, 32'h0, 2, 0, 1'b0);
        check("lb13u_data", resp_rdata, 32'h0000_0080);
        run_req("lb12s", 1'b0, 2'b00, 1'b1, 16'h0012, 32'h0, 2, 0, 1'b0);
        check("lb12s_data", resp_rdata, 32'hFFFF_FFFF);
        run_req("lh12s", 1'b0, 2'b01, 1'b1, 16'h0012, 32'h0, 2, 0, 1'b0);
        check("lh12s_data", resp_rdata, 32'hFFFF_80FF);
        run_req("lh10u", 1'b0, 2'b01, 1'b0, 16'h0010, 32'h0, 2, 0, 1'b0);
        check("lh10u_data", resp_rdata, 32'h0000_7F01);

        run_req("ws_1122", 1'b1, 2'b10, 1'b0, 16'h0010, 32'h1122_3344, 2, 1, 1'b0);
        run_req("sh12", 1'b1, 2'b01, 1'b0, 16'h0012, 32'h5555_ABCD, 3, 2, 1'b0);
        check("sh12_data", last_wdata, 32'hABCD_3344);
        run_req("lw10", 1'b0, 2'b10, 1'b1, 16'h0010, 32'h0, 2, 0, 1'b0);
        check("lw10_data", resp_rdata, 32'hABCD_3344);
        run_req("sb11", 1'b1, 2'b00, 1'b0, 16'h0011, 32'h1234_56EE, 3, 2, 1'b0);
        check("sb11_mem", mem[4], 32'hABCD_EE44);

        run_req("err_ld", 1'b0, 2'b11, 1'b0, 16'h0010, 32'h0, 1, 0, 1'b1);
        check("err_ld_rdata", resp_rdata, 32'hABCD_3344);
        run_req("err_st", 1'b1, 2'b11, 1'b0, 16'h0010, 32'hFFFF_FFFF, 1, 0, 1'b1);
        check("err_st_mem", mem[4], 32'hABCD_EE44);

`ifdef MAU_MISALIGN_TRAP_EN
        run_req("mis_lw", 1'b0, 2'b10, 1'b0, 16'h0001, 32'h0, 1, 0, 1'b1);
        check("mis_lw_rdata", resp_rdata, 32'hABCD_3344);
`else
        run_req("mis_lw", 1'b0, 2'b10, 1'b0, 16'h0001, 32'h0, 2, 0, 1'b0);
        check("mis_lw_rdata", resp_rdata, 32'hCAFE_F00D);
`endif

        run_req("ws_top", 1'b1, 2'b10, 1'b0, 16'hFFFC, 32'h0BAD_CAFE, 2, 1, 1'b0);
        check("ws_top_addr", {16'b0, last_waddr}, 32'h0000_3FFF);
        run_req("lb_top", 1'b0, 2'b00, 1'b0, 16'hFFFF, 32'h0, 2, 0, 1'b0);
        check("lb_top_data", resp_rdata, 32'h0000_000B);

        // Byte store aborted by reset during its WRITE cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 16'h0010; req_wdata = 32'h0000_0099;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_we_before", {31'b0, mem_write_en}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_we_after", {31'b0, mem_write_en}, 32'd0);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        resp_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) resp_cnt++;
        end
        check("abort_no_resp", resp_cnt, 0);
        check("abort_mem", mem[4], 32'hABCD_EE44);

        // req_valid held high: one accept per three-cycle load transaction.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 16'h0010; req_wdata = '0;
        acc = 0; resp_cnt = 0; rdy_bits = '0;
        for (int c = 0; c < 9; c++) begin
            rdy_bits[c] = req_ready;
            if (req_ready) acc++;
            if (resp_valid) resp_cnt++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("hold_ready_bits", {23'b0, rdy_bits}, 32'h0000_0049);
        check("hold_accepts", acc, 3);
        check("hold_resps", resp_cnt, 3);
        check("hold_rdata", resp_rdata, 32'hABCD_EE44);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
